serial_magnitude_comparator: RTL and testbench
==============================================

// Module: serial_magnitude_comparator
// PURPOSE
//  Sequential, bit-serial counterpart of the eight-bit combinational comparator.
//  Latches an operand pair on a start handshake, scans one bit per clock MSB-first,
//  and terminates early at the first differing bit.
//  Returns less/equal/greater flags with a one-cycle done pulse. Intended for
//  area-constrained datapaths where one compare per several cycles suffices.
// PARAMETERS
//  WIDTH  8  operand width in bits (>=2)
// PORTS
//  clk     in   1      single clock, rising edge
//  rst_n   in   1      asynchronous, active-low reset
//  start   in   1      request compare; accepted only in IDLE
//  a       in   WIDTH  operand A, sampled on accepted start
//  b       in   WIDTH  operand B, sampled on accepted start
//  busy    out  1      high in SCAN and DONE (state != IDLE)
//  done    out  1      one-cycle pulse, result valid
//  l_out   out  1      A < B
//  e_out   out  1      A == B
//  g_out   out  1      A > B
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; busy, done, l_out, e_out, g_out = 0;
//    operand regs and bit index cleared. Reset mid-SCAN aborts with no done pulse.
//  - FSM: IDLE -> SCAN on start=1 (cycle 0): latch a/b into a_q/b_q, idx=WIDTH-1.
//    SCAN: examine a_q[idx] vs b_q[idx] each cycle.
//      Bits differ: set decision, go to DONE.
//      Equal with idx==0: decision=equal, go to DONE.
//      Otherwise idx<=idx-1, stay in SCAN.
//    DONE: done=1 for exactly this cycle, flags updated same cycle, -> IDLE.
//  - Latency: first differing bit k gives done (WIDTH-k)+1 cycles after start cycle.
//    Fully equal gives WIDTH+1. Min 2, max WIDTH+1.
//  - Flags: exactly one of l/e/g high after first result, held until next DONE.
//    They are not cleared on start.
//  - start while busy (SCAN or DONE) ignored; a/b changes after acceptance ignored.
//  - Back-to-back: next start accepted in the IDLE cycle after DONE.
//  - idx is ceil(log2(WIDTH)) bits. No wrap: idx never decrements below 0.
// CONFIGURATION
//  SIGNED_CMP_EN defined: operands are two's complement. At idx==WIDTH-1 a
//    differing sign bit inverts the decision (a_q[MSB]=1 -> l_out).
//    Lower bits compare as unsigned.
//  SIGNED_CMP_EN undefined: pure unsigned compare at every bit.
//  Latency is identical in both builds.
// TESTING
//  1 rst_n low mid-run, released -> all outputs 0, busy 0; assert during SCAN -> no done.
//  2 A=25,B=25 start -> done at cycle 9, e_out=1, l_out=g_out=0; busy cycles 1..9.
//  3 A=128,B=127 start -> unsigned: done at cycle 2, g_out=1.
//    With SIGNED_CMP_EN: done at cycle 2, l_out=1.
//  4 A=39,B=16 -> done at cycle 4, g_out=1. A=37,B=79 -> done at cycle 3, l_out=1.
//  5 A=20,B=100 start, then start=1 with A=200,B=0 during SCAN -> second request
//    ignored; done at cycle 3, l_out=1; flags held until next done.
//  6 back-to-back: start again in IDLE cycle after DONE (A=0,B=0) -> accepted,
//    e_out=1 after WIDTH+1 cycles; prior l_out held until that done.

Source files
------------

// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - bit-serial MSB-first magnitude comparator with early termination
// Optional build macro: SIGNED_CMP_EN (two's complement operands)
module serial_magnitude_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             l_out,
  output logic             e_out,
  output logic             g_out
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IW-1:0]    r_idx;
  logic             r_l;
  logic             r_e;
  logic             r_g;

  logic w_bit_a;
  logic w_bit_b;
  logic w_diff;
  logic w_last;
  logic w_a_greater;

  assign w_bit_a = r_a[r_idx];
  assign w_bit_b = r_b[r_idx];
  assign w_diff  = w_bit_a ^ w_bit_b;
  assign w_last  = (r_idx == '0);

`ifdef SIGNED_CMP_EN
  // A set sign bit means the smaller value, so the MSB decision is inverted.
  logic w_msb;
  assign w_msb       = (r_idx == IW'(WIDTH - 1));
  assign w_a_greater = w_msb ? ~w_bit_a : w_bit_a;
`else
  assign w_a_greater = w_bit_a;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SCAN;
      S_SCAN:  if (w_diff || w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Flags load on the SCAN->DONE edge so they are valid alongside the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_idx <= '0;
      r_l   <= 1'b0;
      r_e   <= 1'b0;
      r_g   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_idx <= IW'(WIDTH - 1);
          end
        end
        S_SCAN: begin
          if (w_diff) begin
            r_l <= ~w_a_greater;
            r_e <= 1'b0;
            r_g <= w_a_greater;
          end else if (w_last) begin
            r_l <= 1'b0;
            r_e <= 1'b1;
            r_g <= 1'b0;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (r_state != S_IDLE);
  assign done  = (r_state == S_DONE);
  assign l_out = r_l;
  assign e_out = r_e;
  assign g_out = r_g;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb/tb_serial_magnitude_comparator.sv - self-checking bench for serial_magnitude_comparator
module tb_serial_magnitude_comparator;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, l_out, e_out, g_out;

  int n_tests = 0;
  int n_fail  = 0;

  serial_magnitude_comparator #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .l_out(l_out), .e_out(e_out), .g_out(g_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: latency from the first differing bit, result from plain arithmetic.
  function automatic int lat_of(input logic [W-1:0] x, input logic [W-1:0] y);
    for (int k = W - 1; k >= 0; k--)
      if (x[k] != y[k]) return W - k + 1;
    return W + 1;
  endfunction

  function automatic logic [2:0] res_of(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SIGNED_CMP_EN
    if ($signed(x) < $signed(y)) return 3'b100;
    if ($signed(x) > $signed(y)) return 3'b001;
`else
    if (x < y) return 3'b100;
    if (x > y) return 3'b001;
`endif
    return 3'b010;
  endfunction

  logic       m_active = 1'b0;
  int         m_t      = 0;
  int         m_lat    = 0;
  logic [2:0] m_res    = 3'b000;
  logic [2:0] m_flags  = 3'b000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_t      = 0;
      m_flags  = 3'b000;
    end else if (m_active) begin
      if (m_t == m_lat) begin
        m_active = 1'b0;
      end else begin
        m_t++;
        if (m_t == m_lat) m_flags = m_res;
      end
    end else if (start) begin
      m_active = 1'b1;
      m_t      = 1;
      m_lat    = lat_of(a, b);
      m_res    = res_of(a, b);
    end
  end

  always @(negedge clk) begin
    chk("busy", int'(busy), int'(m_active));
    chk("done", int'(done), int'(m_active && (m_t == m_lat)));
    chk("flags", int'({l_out, e_out, g_out}), int'(m_flags));
  end

  // Start a compare; optionally re-request with other operands while busy.
  task automatic run(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                     input int exp_lat, input logic [2:0] exp_flags, input bit spoil);
    int cyc;
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 20) begin
      if (spoil) begin
        a = 8'd200; b = 8'd0; start = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({name, "_latency"}, cyc, exp_lat);
    chk({name, "_flags"}, int'({l_out, e_out, g_out}), int'(exp_flags));
  endtask

  initial begin
    int n_done;
    repeat (2) @(negedge clk);
    chk("reset_outputs", int'({busy, done, l_out, e_out, g_out}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run("eq_25_25", 8'd25, 8'd25, 9, 3'b010, 1'b0);
    @(negedge clk);
`ifdef SIGNED_CMP_EN
    run("msb_128_127", 8'd128, 8'd127, 2, 3'b100, 1'b0);
`else
    run("msb_128_127", 8'd128, 8'd127, 2, 3'b001, 1'b0);
`endif
    run("gt_39_16", 8'd39, 8'd16, 4, 3'b001, 1'b0);
    run("lt_37_79", 8'd37, 8'd79, 3, 3'b100, 1'b0);
    run("lsb_255_254", 8'd255, 8'd254, 9, 3'b001, 1'b0);
    repeat (3) @(negedge clk);
    run("ignored_start", 8'd20, 8'd100, 3, 3'b100, 1'b1);

    // Back-to-back: the next start lands in the IDLE cycle after DONE.
    @(negedge clk);
    chk("idle_after_done_busy", int'(busy), 0);
    chk("held_l_idle", int'(l_out), 1);
    a = 8'd0; b = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_accepted_busy", int'(busy), 1);
    chk("held_l_scan", int'(l_out), 1);
    n_done = 1;
    while (!done && n_done < 20) begin
      @(negedge clk);
      n_done++;
    end
    chk("b2b_latency", n_done, 9);
    chk("b2b_flags", int'({l_out, e_out, g_out}), 3'b010);

    // Abort mid-scan with reset.
    @(negedge clk);
    a = 8'd5; b = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_busy", int'(busy), 1);
    #1 rst_n = 1'b0;
    #1 chk("abort_outputs", int'({busy, done, l_out, e_out, g_out}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("no_done_after_abort", n_done, 0);
    chk("idle_after_abort", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
